// File: rtl/class_tree_pkg.sv
// Shared types and width helpers for the table-driven decision-tree engine.
// The optional perf counters are enabled by defining CLASS_TREE_PERF_EN.
package class_tree_pkg;

   typedef enum logic [1:0] {StIdle, StWalk, StDone} state_e;

   // Index width for n items, never narrower than one bit.
   function automatic int unsigned idx_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int unsigned entry_w(input int unsigned n_feat, input int unsigned n_nodes);
      return 1 + idx_w(n_feat) + 2 * idx_w(n_nodes);
   endfunction

   // Field LSB offsets inside an entry laid out as {leaf, feat_idx, t_child, f_child}.
   function automatic int unsigned f_child_lsb();
      return 0;
   endfunction

   function automatic int unsigned t_child_lsb(input int unsigned n_nodes);
      return idx_w(n_nodes);
   endfunction

   function automatic int unsigned feat_lsb(input int unsigned n_nodes);
      return 2 * idx_w(n_nodes);
   endfunction

   function automatic int unsigned leaf_bit(input int unsigned n_feat, input int unsigned n_nodes);
      return 2 * idx_w(n_nodes) + idx_w(n_feat);
   endfunction

   localparam int unsigned DefNFeat  = 51;
   localparam int unsigned DefNNodes = 64;
   localparam int unsigned DefFeatW  = idx_w(DefNFeat);
   localparam int unsigned DefNodeW  = idx_w(DefNNodes);

   typedef struct packed {
      logic                leaf;
      logic [DefFeatW-1:0] feat_idx;
      logic [DefNodeW-1:0] t_child;
      logic [DefNodeW-1:0] f_child;
   } node_entry_t;

endpackage

// File: rtl/class_tree_node_ram.sv
// Node table: register array with one write port and one asynchronous read port.
// Reset turns every entry into a class-0 leaf.
module class_tree_node_ram #(
   parameter int unsigned N_NODES = 64,
   parameter int unsigned NODE_W  = 6,
   parameter int unsigned ENTRY_W = 19
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               we,
   input  logic [NODE_W-1:0]  waddr,
   input  logic [ENTRY_W-1:0] wdata,
   input  logic [NODE_W-1:0]  raddr,
   output logic [ENTRY_W-1:0] rdata
);

   localparam logic [ENTRY_W-1:0] LeafInit = {1'b1, {(ENTRY_W-1){1'b0}}};

   logic [ENTRY_W-1:0] mem_q [N_NODES];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < int'(N_NODES); i++) begin
            mem_q[i] <= LeafInit;
         end
      end else if (we && (int'(waddr) < int'(N_NODES))) begin
         mem_q[waddr] <= wdata;
      end
   end

   // Pointers past the table end read as a class-0 leaf so a walk always terminates.
   always_comb begin
      rdata = LeafInit;
      if (int'(raddr) < int'(N_NODES)) begin
         rdata = mem_q[raddr];
      end
   end

endmodule

// File: rtl/class_tree_engine.sv
// Sequential decision-tree classifier walking one node-table entry per clock.
// Define CLASS_TREE_PERF_EN to add the perf_done/perf_err saturating counters.
module class_tree_engine
   import class_tree_pkg::*;
#(
   parameter int unsigned N_FEAT    = 51,
   parameter int unsigned N_NODES   = 64,
   parameter int unsigned CLASS_W   = 1,
   parameter int unsigned MAX_STEPS = N_NODES,
   localparam int unsigned FEAT_W   = idx_w(N_FEAT),
   localparam int unsigned NODE_W   = idx_w(N_NODES),
   localparam int unsigned ENTRY_W  = entry_w(N_FEAT, N_NODES)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [N_FEAT-1:0]  in_feat,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [CLASS_W-1:0] out_class,
   output logic               out_err,
   input  logic               cfg_we,
   input  logic [NODE_W-1:0]  cfg_addr,
   input  logic [ENTRY_W-1:0] cfg_data,
   output logic               cfg_busy
`ifdef CLASS_TREE_PERF_EN
   ,
   output logic [31:0]        perf_done,
   output logic [31:0]        perf_err
`endif
);

   localparam int unsigned STEP_W   = idx_w(MAX_STEPS);
   localparam int unsigned LEAF_BIT = leaf_bit(N_FEAT, N_NODES);
   localparam int unsigned FEAT_LSB = feat_lsb(N_NODES);
   localparam int unsigned T_LSB    = t_child_lsb(N_NODES);
   localparam int unsigned F_LSB    = f_child_lsb();

   state_e              state_q;
   logic [N_FEAT-1:0]   feat_q;
   logic [NODE_W-1:0]   ptr_q;
   logic [STEP_W-1:0]   steps_q;

   logic [ENTRY_W-1:0]  entry;
   logic                leaf;
   logic [FEAT_W-1:0]   feat_idx;
   logic [NODE_W-1:0]   t_child;
   logic [NODE_W-1:0]   f_child;
   logic                feat_bit;
   logic [NODE_W-1:0]   next_node;
   logic                table_we;

   assign table_we = cfg_we && (state_q == StIdle);

   class_tree_node_ram #(
      .N_NODES (N_NODES),
      .NODE_W  (NODE_W),
      .ENTRY_W (ENTRY_W)
   ) u_node_ram (
      .clk   (clk),
      .rst   (rst),
      .we    (table_we),
      .waddr (cfg_addr),
      .wdata (cfg_data),
      .raddr (ptr_q),
      .rdata (entry)
   );

   assign leaf     = entry[LEAF_BIT];
   assign feat_idx = entry[FEAT_LSB +: FEAT_W];
   assign t_child  = entry[T_LSB +: NODE_W];
   assign f_child  = entry[F_LSB +: NODE_W];

   // Feature indices beyond the vector read as zero, i.e. take the false branch.
   always_comb begin
      feat_bit = 1'b0;
      if (int'(feat_idx) < int'(N_FEAT)) begin
         feat_bit = feat_q[feat_idx];
      end
   end

   assign next_node = feat_bit ? t_child : f_child;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         feat_q    <= '0;
         ptr_q     <= '0;
         steps_q   <= '0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         out_class <= '0;
         out_err   <= 1'b0;
         cfg_busy  <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (in_valid) begin
                  feat_q   <= in_feat;
                  ptr_q    <= '0;
                  steps_q  <= '0;
                  in_ready <= 1'b0;
                  cfg_busy <= 1'b1;
                  state_q  <= StWalk;
               end
            end
            StWalk: begin
               if (leaf) begin
                  out_class <= f_child[CLASS_W-1:0];
                  out_err   <= 1'b0;
                  out_valid <= 1'b1;
                  state_q   <= StDone;
               end else if (steps_q == STEP_W'(MAX_STEPS - 1)) begin
                  out_class <= '0;
                  out_err   <= 1'b1;
                  out_valid <= 1'b1;
                  state_q   <= StDone;
               end else begin
                  ptr_q   <= next_node;
                  steps_q <= steps_q + 1'b1;
               end
            end
            StDone: begin
               // Always return to IDLE so accept and consume never share a cycle.
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  cfg_busy  <= 1'b0;
                  state_q   <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

`ifdef CLASS_TREE_PERF_EN
   logic done_hs;
   assign done_hs = (state_q == StDone) && out_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         perf_done <= '0;
         perf_err  <= '0;
      end else if (done_hs) begin
         if (perf_done != '1) begin
            perf_done <= perf_done + 32'd1;
         end
         if (out_err && (perf_err != '1)) begin
            perf_err <= perf_err + 32'd1;
         end
      end
   end
`endif

endmodule
